pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter FORWARD_EN, default 0; 1 = forwarding present, so only load-use hazards stall.
REQ-002 SHALL have parameter WAIT_LIMIT, default 16; maximum consecutive memory-wait cycles before timeout.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have ports:
- src1 input 4: ID Rn index.
- src2 input 4: ID Rm/Rd index.
- with_src1 input 1: ID reads src1.
- with_src2 input 1: ID reads src2.
- exe_dest input 4: EXE stage destination register.
- exe_wb_en input 1: EXE stage writes back.
- exe_mem_r_en input 1: EXE stage holds a load.
- mem_dest input 4: MEM stage destination register.
- mem_wb_en input 1: MEM stage writes back.
- mem_req input 1: MEM stage holds a load or store.
- mem_ready input 1: data memory completes the access this cycle.
- branch_taken input 1: EXE stage resolved a taken branch.
- hazard output 1: to the ID stage; zeroes control and holds PC and IF/ID.
- flush output 1: clears IF/ID and ID/EXE.
- freeze output 1: holds every pipeline register and the PC.
- mem_timeout output 1: sticky error flag.
- stall_cnt output 16: hazard-cycle count.
- flush_cnt output 16: flush-event count.

Function
REQ-005 SHALL compute raw_hz combinationally:
- (with_src1 & src1==exe_dest) or (with_src2 & src2==exe_dest), gated by exe_wb_en when FORWARD_EN=0 and by exe_mem_r_en when FORWARD_EN=1;
- OR, only when FORWARD_EN=0: the same comparisons against mem_dest, gated by mem_wb_en.
REQ-006 SHALL drive flush = branch_taken & ~freeze, in the same cycle (zero latency).
REQ-007 SHALL drive hazard = raw_hz & ~branch_taken & ~freeze, so flush overrides hazard.
REQ-008 SHALL implement FSM states RUN and MEM_WAIT, with a 16-bit wait counter wcnt.
REQ-009 In RUN: if mem_req & ~mem_ready, SHALL go to MEM_WAIT with wcnt=1; otherwise SHALL stay in RUN.
REQ-010 In MEM_WAIT: if mem_ready, SHALL return to RUN with wcnt=0.
REQ-011 In MEM_WAIT: else if wcnt==WAIT_LIMIT, SHALL set mem_timeout, return to RUN and clear wcnt.
REQ-012 In MEM_WAIT: otherwise SHALL increment wcnt.
REQ-013 SHALL drive freeze = mem_req & ~mem_ready & ~(state==MEM_WAIT & wcnt==WAIT_LIMIT), so the timeout cycle releases the pipeline.
REQ-014 mem_timeout SHALL be sticky; only rst clears it.
REQ-015 stall_cnt SHALL increment on each clk edge where hazard=1.
REQ-016 flush_cnt SHALL increment on each clk edge where flush=1.
REQ-017 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-018 When mem_ready and mem_req rise in the same cycle, SHALL assert no freeze and stay in RUN.
REQ-019 A register index of 4'd15 SHALL be compared like any other index, with no special case.

Reset
REQ-020 On rst, asynchronously: state=RUN, wcnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-021 Combinational outputs SHALL follow their inputs during reset; counters SHALL not count while rst=1.
REQ-022 Reset asserted mid-MEM_WAIT SHALL abandon the wait; the first post-reset cycle SHALL be in RUN.

Structure
REQ-023 State encoding (RUN=1'b0, MEM_WAIT=1'b1) and the EXE_* command constants SHALL live in the shared package.
REQ-024 One sub-module, sat_counter16 (enable, saturate), SHALL be instantiated twice, for stall_cnt and flush_cnt.
REQ-025 All logic other than the FSM, the wait counter and the counters SHALL be combinational.

Verification
REQ-026 Load-use, FORWARD_EN=1: exe_mem_r_en=1, exe_dest=3, src1=3, with_src1=1 -> hazard=1 for 1 cycle, stall_cnt=1.
REQ-027 Priority: branch_taken=1 together with raw_hz=1 -> flush=1, hazard=0, flush_cnt increments by 1, stall_cnt unchanged.
REQ-028 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze=1 for 3 cycles, FSM back in RUN, mem_timeout=0.
REQ-029 Timeout, WAIT_LIMIT=4: mem_ready held 0 -> freeze released on the wait cycle where wcnt=4, mem_timeout=1 and stays 1.
REQ-030 Saturation: 70000 hazard cycles -> stall_cnt=16'hFFFF.
REQ-031 Reset: rst pulsed during MEM_WAIT -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the hazard / flush / freeze controller.
// Holds the memory-wait FSM encoding and the EXE command set.
package pipeline_controller_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EXE_RUN    = 2'd0,
        EXE_HAZARD = 2'd1,
        EXE_FLUSH  = 2'd2,
        EXE_FREEZE = 2'd3
    } exe_cmd_t;

    function automatic logic reads_reg(
        input logic [REG_W-1:0] s1,
        input logic [REG_W-1:0] s2,
        input logic             w1,
        input logic             w2,
        input logic [REG_W-1:0] dest
    );
        return (w1 && (s1 == dest)) || (w2 && (s2 == dest));
    endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import pipeline_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/flush/freeze controller with memory-wait timeout
// and saturating stall/flush event counters.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int FORWARD_EN = 0,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             with_src1,
    input  logic             with_src2,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             hazard,
    output logic             flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic FWD = (FORWARD_EN != 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_timeout;

    logic     w_exe_match;
    logic     w_mem_match;
    logic     w_exe_gate;
    logic     w_raw_hz;
    logic     w_wait_max;
    logic     w_freeze;
    exe_cmd_t w_cmd;

    assign w_exe_match = reads_reg(src1, src2, with_src1, with_src2, exe_dest);
    assign w_mem_match = reads_reg(src1, src2, with_src1, with_src2, mem_dest);

    // With forwarding only a load in EXE cannot be bypassed.
    assign w_exe_gate = FWD ? exe_mem_r_en : exe_wb_en;
    assign w_raw_hz   = (w_exe_gate & w_exe_match)
                      | (~FWD & mem_wb_en & w_mem_match);

    assign w_wait_max = (r_state == MEM_WAIT) && (r_wcnt == LIMIT);
    assign w_freeze   = mem_req & ~mem_ready & ~w_wait_max;

    always_comb begin
        w_cmd = EXE_RUN;
        unique case (1'b1)
            w_freeze:                             w_cmd = EXE_FREEZE;
            ~w_freeze & branch_taken:             w_cmd = EXE_FLUSH;
            ~w_freeze & ~branch_taken & w_raw_hz: w_cmd = EXE_HAZARD;
            default:                              w_cmd = EXE_RUN;
        endcase
    end

    assign hazard = (w_cmd == EXE_HAZARD);
    assign flush  = (w_cmd == EXE_FLUSH);
    assign freeze = (w_cmd == EXE_FREEZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                        r_wcnt  <= '0;
                    end else if (r_wcnt == LIMIT) begin
                        r_state   <= RUN;
                        r_wcnt    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign mem_timeout = r_timeout;

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (hazard),
        .o_count (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (flush),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: two controllers (no forwarding / forwarding),
// table vectors, directed corner sequences and a random model run.
module tb_pipeline_controller;

    localparam int LIM = 4;

    logic       clk;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       with_src1, with_src2, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_req, mem_ready, branch_taken;

    logic [1:0]       hz, fl, fz, to;
    logic [1:0][15:0] sc, fc;

    int errors = 0;
    int checks = 0;

    int m_wait  [2];
    bit m_to    [2];
    int m_stall [2];
    int m_flush [2];

    pipeline_controller #(.FORWARD_EN(0), .WAIT_LIMIT(LIM)) u_dut0 (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2),
        .with_src1(with_src1), .with_src2(with_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .hazard(hz[0]), .flush(fl[0]), .freeze(fz[0]),
        .mem_timeout(to[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    pipeline_controller #(.FORWARD_EN(1), .WAIT_LIMIT(LIM)) u_dut1 (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2),
        .with_src1(with_src1), .with_src2(with_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .hazard(hz[1]), .flush(fl[1]), .freeze(fz[1]),
        .mem_timeout(to[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t",
                     nm, d, act, exp, $time);
        end
    endtask

    // Reference model: rules evaluated directly on the current inputs.
    function automatic bit m_raw(input int fe);
        bit rd_exe, rd_mem, r;
        rd_exe = (with_src1 && src1 == exe_dest) ||
                 (with_src2 && src2 == exe_dest);
        rd_mem = (with_src1 && src1 == mem_dest) ||
                 (with_src2 && src2 == mem_dest);
        r = rd_exe && (fe != 0 ? exe_mem_r_en : exe_wb_en);
        if (fe == 0 && mem_wb_en && rd_mem) r = 1'b1;
        return r;
    endfunction

    // m_wait = cycles already spent waiting (0 = not waiting)
    function automatic bit m_fz(input int d);
        return mem_req && !mem_ready && !(m_wait[d] == LIM);
    endfunction

    function automatic bit m_fl(input int d);
        return branch_taken && !m_fz(d);
    endfunction

    function automatic bit m_hz(input int d);
        return m_raw(d) && !branch_taken && !m_fz(d);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_wait[d]  = 0;
            m_to[d]    = 1'b0;
            m_stall[d] = 0;
            m_flush[d] = 0;
        end
    endtask

    task automatic m_clock();
        for (int d = 0; d < 2; d++) begin
            if (m_hz(d) && m_stall[d] < 65535) m_stall[d]++;
            if (m_fl(d) && m_flush[d] < 65535) m_flush[d]++;
            if (m_wait[d] == 0) begin
                if (mem_req && !mem_ready) m_wait[d] = 1;
            end else if (mem_ready) begin
                m_wait[d] = 0;
            end else if (m_wait[d] == LIM) begin
                m_to[d]   = 1'b1;
                m_wait[d] = 0;
            end else begin
                m_wait[d]++;
            end
        end
    endtask

    // Called at posedge+1 with inputs set; returns at next posedge+1.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("hazard",    d, 32'(hz[d]), 32'(m_hz(d)));
            chk("flush",     d, 32'(fl[d]), 32'(m_fl(d)));
            chk("freeze",    d, 32'(fz[d]), 32'(m_fz(d)));
            chk("timeout",   d, 32'(to[d]), 32'(m_to[d]));
            chk("stall_cnt", d, 32'(sc[d]), 32'(m_stall[d]));
            chk("flush_cnt", d, 32'(fc[d]), 32'(m_flush[d]));
        end
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic clear_in();
        src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
        with_src1 = 0; with_src2 = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        mem_req = 0; mem_ready = 0; branch_taken = 0;
    endtask

    task automatic load_use();
        src1 = 4'd3; with_src1 = 1'b1; exe_dest = 4'd3;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    endtask

    typedef struct {
        logic [3:0] s1, s2;
        logic       w1, w2;
        logic [3:0] ed;
        logic       ewb, emr;
        logic [3:0] md;
        logic       mwb, req, rdy, bt;
        logic       hz0, hz1, fl, fz;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 3);
        return (r == 3) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[2]  = '{3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[3]  = '{0, 5, 0, 1, 9, 1, 0, 5, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[4]  = '{3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[5]  = '{0, 15, 0, 1, 15, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0};
        tbl[7]  = '{3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 1,  0, 0, 0, 1};
        tbl[8]  = '{3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1, 0,  1, 1, 0, 0};
        tbl[9]  = '{2, 0, 1, 0, 3, 1, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[10] = '{3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0};
        tbl[11] = '{1, 4, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0};
        tbl[12] = '{7, 15, 1, 1, 15, 0, 0, 15, 1, 0, 0, 0, 1, 0, 0, 0};

        clear_in();
        rst = 1'b0;
        #2 rst = 1'b1;
        m_reset();

        // Combinational vectors applied while held in reset.
        for (int i = 0; i < 13; i++) begin
            src1 = tbl[i].s1; src2 = tbl[i].s2;
            with_src1 = tbl[i].w1; with_src2 = tbl[i].w2;
            exe_dest = tbl[i].ed; exe_wb_en = tbl[i].ewb;
            exe_mem_r_en = tbl[i].emr;
            mem_dest = tbl[i].md; mem_wb_en = tbl[i].mwb;
            mem_req = tbl[i].req; mem_ready = tbl[i].rdy;
            branch_taken = tbl[i].bt;
            #3;
            chk("tbl_hazard", 0, 32'(hz[0]), 32'(tbl[i].hz0));
            chk("tbl_hazard", 1, 32'(hz[1]), 32'(tbl[i].hz1));
            chk("tbl_flush",  0, 32'(fl[0]), 32'(tbl[i].fl));
            chk("tbl_flush",  1, 32'(fl[1]), 32'(tbl[i].fl));
            chk("tbl_freeze", 0, 32'(fz[0]), 32'(tbl[i].fz));
            chk("tbl_freeze", 1, 32'(fz[1]), 32'(tbl[i].fz));
        end
        for (int d = 0; d < 2; d++) begin
            chk("rst_stall_cnt", d, 32'(sc[d]), 0);
            chk("rst_flush_cnt", d, 32'(fc[d]), 0);
            chk("rst_timeout",   d, 32'(to[d]), 0);
        end

        clear_in();
        @(posedge clk);
        #1 rst = 1'b0;

        // Load-use: one stall cycle.
        load_use();
        step();
        clear_in();
        step();
        chk("lu_stall_cnt", 1, 32'(sc[1]), 1);

        // Branch with a pending hazard: flush wins.
        load_use();
        branch_taken = 1'b1;
        step();
        chk("prio_flush_cnt", 1, 32'(fc[1]), 1);
        chk("prio_stall_cnt", 1, 32'(sc[1]), 1);

        // Three wait cycles then ready.
        clear_in();
        mem_req = 1'b1;
        repeat (3) step();
        mem_ready = 1'b1;
        #1 chk("wait_release", 0, 32'(fz[0]), 0);
        step();
        step();
        chk("wait_timeout", 0, 32'(to[0]), 0);

        // Timeout: released on the cycle where wcnt reaches the limit.
        mem_ready = 1'b0;
        repeat (LIM) step();
        #1 chk("to_release", 0, 32'(fz[0]), 0);
        step();
        chk("to_set", 0, 32'(to[0]), 1);
        mem_req = 1'b0;
        repeat (3) step();
        chk("to_sticky", 1, 32'(to[1]), 1);

        // Async reset during a wait.
        mem_req = 1'b1;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_timeout", 0, 32'(to[0]), 0);
        chk("arst_stall",   0, 32'(sc[0]), 0);
        chk("arst_flush",   0, 32'(fc[0]), 0);
        chk("arst_freeze",  0, 32'(fz[0]), 1);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step();
        mem_ready = 1'b1;
        step();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            src1 = pick_reg(); src2 = pick_reg();
            exe_dest = pick_reg(); mem_dest = pick_reg();
            with_src1 = 1'($urandom); with_src2 = 1'($urandom);
            exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
            mem_wb_en = 1'($urandom);
            mem_req = ($urandom_range(0, 9) < 3);
            mem_ready = 1'($urandom);
            branch_taken = ($urandom_range(0, 19) < 3);
            step();
        end

        // Saturation of the stall counter.
        clear_in();
        load_use();
        repeat (70000) step();
        chk("sat_stall", 0, 32'(sc[0]), 32'hFFFF);
        chk("sat_stall", 1, 32'(sc[1]), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
